// File: rtl/screen_rotate_mode.sv
// rtl/screen_rotate_mode.sv - double-buffered frame rotator (0/CW/CCW/180) feeding the scaler
//   clk        : system clock
//   reset      : synchronous, active-high
//   ce_pix     : input pixel enable
//   mode       : 0 none, 1 CW, 2 CCW, 3 180; latched at each vblank rising edge
//   video_in   : input pixel
//   hblank     : input horizontal blank
//   vblank     : input vertical blank
//   ce_out     : output slot enable; all reader state advances only when high
//   video_out  : output pixel, 0 whenever de is low
//   hsync      : high during the blank slots after each output line
//   vsync      : high from end of readout until the next swap
//   de         : output pixel valid (active, non-margin region)
//   dropped    : one-cycle pulse when an out-of-range input pixel is discarded
module screen_rotate_mode #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int DEPTH  = 8,
    parameter int MARGIN = 8,
    parameter int HBL    = 4,
    parameter int AW     = $clog2(2*WIDTH*HEIGHT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic [1:0]       mode,
    input  logic [DEPTH-1:0] video_in,
    input  logic             hblank,
    input  logic             vblank,
    input  logic             ce_out,
    output logic [DEPTH-1:0] video_out,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             dropped
);
    localparam int CW = 16;
    localparam logic [CW-1:0] W_C   = CW'(WIDTH);
    localparam logic [CW-1:0] H_C   = CW'(HEIGHT);
    localparam logic [CW-1:0] M_C   = CW'(MARGIN);
    localparam logic [CW-1:0] HBL_C = CW'(HBL);
    localparam logic [AW-1:0] FRM   = AW'(WIDTH*HEIGHT);
    localparam logic [AW-1:0] A_W   = AW'(WIDTH);
    localparam logic [AW-1:0] A_H   = AW'(HEIGHT);
    localparam logic [AW-1:0] INIT1 = AW'(HEIGHT-1);
    localparam logic [AW-1:0] INIT2 = AW'((WIDTH-1)*HEIGHT);
    localparam logic [AW-1:0] INIT3 = AW'(WIDTH*HEIGHT-1);

    typedef enum logic {S_IDLE, S_FRAME} state_t;

    logic [DEPTH-1:0] ram [0:2*WIDTH*HEIGHT-1];
    logic [DEPTH-1:0] rd_q;

    logic          wbuf, rbuf;
    logic [1:0]    wmode, rmode;
    logic [CW-1:0] x, y;
    logic [AW-1:0] row, off;
    logic          first_line, blank_q, vblank_q;

    logic          blank, blank_fall, vb_rise, active, in_range, we;
    logic [CW-1:0] cur_x, cur_y;
    logic [AW-1:0] row_next, cur_row, cur_off, pix_off, row_init, waddr;

    state_t        state;
    logic [CW-1:0] rx, ry, ow, oh;
    logic [AW-1:0] raddr;
    logic          last_slot, last_line, act;

    // The blank fall is seen on the first active pixel itself, so the new
    // line's x/y/row are resolved combinationally and that pixel is written
    // at the fresh row start. The fall that opens a frame's first line does
    // not advance y.
    always_comb begin
        blank      = hblank | vblank;
        blank_fall = blank_q & ~blank;
        vb_rise    = vblank & ~vblank_q;
        case (wmode)
            2'd0:    row_next = row + A_W;
            2'd1:    row_next = row - AW'(1);
            2'd2:    row_next = row + AW'(1);
            default: row_next = row - A_W;
        endcase
        cur_x   = blank_fall ? '0 : x;
        cur_y   = y;
        cur_row = row;
        if (blank_fall && !first_line && y < H_C) begin
            cur_y   = y + CW'(1);
            cur_row = row_next;
        end
        cur_off = blank_fall ? cur_row : off;
        case (wmode)
            2'd0:    pix_off = cur_off + AW'(1);
            2'd1:    pix_off = cur_off + A_H;
            2'd2:    pix_off = cur_off - A_H;
            default: pix_off = cur_off - AW'(1);
        endcase
        case (mode)
            2'd0:    row_init = '0;
            2'd1:    row_init = INIT1;
            2'd2:    row_init = INIT2;
            default: row_init = INIT3;
        endcase
        active   = ce_pix & ~hblank & ~vblank;
        in_range = (cur_x < W_C) && (cur_y < H_C);
        we       = active & in_range;
        waddr    = wbuf ? FRM + cur_off : cur_off;
    end

    always_comb begin
        ow        = (rmode == 2'd1 || rmode == 2'd2) ? H_C : W_C;
        oh        = (rmode == 2'd1 || rmode == 2'd2) ? W_C : H_C;
        last_slot = (rx == ow + HBL_C - CW'(1));
        last_line = (ry == oh + M_C + M_C - CW'(1));
        act       = (state == S_FRAME) && (rx < ow) && (ry >= M_C) && (ry < oh + M_C);
    end

    always_ff @(posedge clk) begin
        if (we)
            ram[waddr] <= video_in;
        if (ce_out && act)
            rd_q <= ram[raddr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wbuf       <= 1'b0;
            rbuf       <= 1'b1;
            wmode      <= 2'd0;
            rmode      <= 2'd0;
            x          <= '0;
            y          <= '0;
            row        <= '0;
            off        <= '0;
            first_line <= 1'b1;
            blank_q    <= 1'b1;
            vblank_q   <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            blank_q  <= blank;
            vblank_q <= vblank;
            dropped  <= active & ~in_range;
            if (vb_rise) begin
                wmode      <= mode;
                rmode      <= wmode;
                rbuf       <= wbuf;
                wbuf       <= ~wbuf;
                x          <= '0;
                y          <= '0;
                row        <= row_init;
                off        <= row_init;
                first_line <= 1'b1;
            end else begin
                x          <= we ? cur_x + CW'(1) : cur_x;
                y          <= cur_y;
                row        <= cur_row;
                off        <= we ? pix_off : cur_off;
                first_line <= first_line & ~blank_fall;
            end
        end
    end

    // Outputs describe the slot processed on the previous ce_out, matching
    // the one-slot latency of the RAM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            rx    <= '0;
            ry    <= '0;
            raddr <= '0;
            hsync <= 1'b0;
            vsync <= 1'b1;
            de    <= 1'b0;
        end else if (vb_rise) begin
            state <= S_FRAME;
            rx    <= '0;
            ry    <= '0;
            raddr <= wbuf ? FRM : '0;
            hsync <= 1'b0;
            vsync <= 1'b1;
            de    <= 1'b0;
        end else if (ce_out) begin
            hsync <= (state == S_FRAME) && (rx >= ow);
            vsync <= (state == S_IDLE);
            de    <= act;
            if (act)
                raddr <= raddr + AW'(1);
            if (state == S_FRAME) begin
                if (last_slot) begin
                    rx <= '0;
                    if (last_line) begin
                        state <= S_IDLE;
                        ry    <= '0;
                    end else begin
                        ry <= ry + CW'(1);
                    end
                end else begin
                    rx <= rx + CW'(1);
                end
            end
        end
    end

    assign video_out = de ? rd_q : '0;

    logic unused_rbuf;
    assign unused_rbuf = rbuf;

endmodule

// File: tb/tb_screen_rotate_mode.sv
// tb/tb_screen_rotate_mode.sv - self-checking bench for screen_rotate_mode
module tb_screen_rotate_mode;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int M  = 1;
    localparam int HB = 2;

    logic       clk = 1'b0;
    logic       reset, ce_pix, ce_out, hblank, vblank;
    logic [1:0] mode;
    logic [7:0] video_in, video_out;
    logic       hsync, vsync, de, dropped;

    always #5 clk = ~clk;

    screen_rotate_mode #(
        .WIDTH(W), .HEIGHT(H), .DEPTH(8), .MARGIN(M), .HBL(HB)
    ) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .mode(mode),
        .video_in(video_in), .hblank(hblank), .vblank(vblank), .ce_out(ce_out),
        .video_out(video_out), .hsync(hsync), .vsync(vsync), .de(de),
        .dropped(dropped)
    );

    typedef struct {
        logic [1:0] mode;
        int         ow;
        int         oh;
        logic [7:0] px [12];
    } vec_t;

    typedef struct packed {
        logic       chk;
        logic       de;
        logic       hs;
        logic       vs;
        logic [7:0] pix;
    } exp_t;

    vec_t tbl [4];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   rd_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor_step();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
                check($sformatf("readout[%0d] {de,hs,vs,pix}", rd_idx),
                      32'({de, hsync, vsync, video_out}),
                      32'({e.de, e.hs, e.vs, e.pix}));
                rd_idx++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor_step();
        @(posedge clk);
        #1;
    endtask

    // Expected readout starting at the swap driven now: two swap-latency
    // slots (not compared), every frame slot, then one idle (vsync) slot.
    task automatic push_expected(input int idx);
        exp_t e;
        int   ow;
        int   oh;
        ow = tbl[idx].ow;
        oh = tbl[idx].oh;
        sb.push_back('0);
        sb.push_back('0);
        for (int ry = 0; ry < oh + 2*M; ry++) begin
            for (int rx = 0; rx < ow + HB; rx++) begin
                e = '0;
                e.chk = 1'b1;
                if (rx >= ow) begin
                    e.hs = 1'b1;
                end else if (ry >= M && ry < M + oh) begin
                    e.de  = 1'b1;
                    e.pix = tbl[idx].px[(ry-M)*ow + rx];
                end
                sb.push_back(e);
            end
        end
        e = '0;
        e.chk = 1'b1;
        e.vs  = 1'b1;
        sb.push_back(e);
    endtask

    // One input frame: 10 vblank cycles, then 3 lines of 4 pixels (5 on
    // extra_line) each followed by 6 hblank cycles. Pixel = y*4+x.
    task automatic drive_frame(input int push_idx, input int extra_line,
                               input int sw_mode, input int rst_at);
        int n;
        vblank = 1'b1;
        hblank = 1'b1;
        if (push_idx >= 0)
            push_expected(push_idx);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rst_at >= 0 && i == rst_at) begin
                check("pre_reset de", 32'(de), 32'(1));
                check("pre_reset video_out", 32'(video_out), 32'(1));
                reset = 1'b1;
            end
            if (rst_at >= 0 && i == rst_at + 1) begin
                check("post_reset vsync", 32'(vsync), 32'(1));
                check("post_reset de", 32'(de), 32'(0));
                check("post_reset hsync", 32'(hsync), 32'(0));
                check("post_reset video_out", 32'(video_out), 32'(0));
                reset = 1'b0;
            end
        end
        vblank = 1'b0;
        for (int ln = 0; ln < 3; ln++) begin
            n = (ln == extra_line) ? 5 : 4;
            hblank = 1'b0;
            for (int px = 0; px < n; px++) begin
                video_in = (px < 4) ? 8'(ln*4 + px) : 8'hAA;
                tick();
                if (ln == extra_line)
                    check($sformatf("dropped px%0d", px), 32'(dropped), 32'(px == 4));
            end
            hblank = 1'b1;
            if (ln == 0 && sw_mode >= 0)
                mode = 2'(sw_mode);
            for (int j = 0; j < 6; j++) begin
                tick();
                if (ln == extra_line && j == 0)
                    check("dropped after pulse", 32'(dropped), 32'(0));
            end
        end
    endtask

    initial begin
        tbl[0].mode = 2'd0; tbl[0].ow = 4; tbl[0].oh = 3;
        tbl[0].px = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11};
        tbl[1].mode = 2'd1; tbl[1].ow = 3; tbl[1].oh = 4;
        tbl[1].px = '{8'd8, 8'd4, 8'd0, 8'd9, 8'd5, 8'd1, 8'd10, 8'd6, 8'd2, 8'd11, 8'd7, 8'd3};
        tbl[2].mode = 2'd2; tbl[2].ow = 3; tbl[2].oh = 4;
        tbl[2].px = '{8'd3, 8'd7, 8'd11, 8'd2, 8'd6, 8'd10, 8'd1, 8'd5, 8'd9, 8'd0, 8'd4, 8'd8};
        tbl[3].mode = 2'd3; tbl[3].ow = 4; tbl[3].oh = 3;
        tbl[3].px = '{8'd11, 8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};

        reset    = 1'b1;
        ce_pix   = 1'b1;
        ce_out   = 1'b1;
        hblank   = 1'b1;
        vblank   = 1'b0;
        video_in = '0;
        mode     = 2'd0;
        repeat (3) tick();
        check("reset vsync", 32'(vsync), 32'(1));
        check("reset de", 32'(de), 32'(0));
        check("reset hsync", 32'(hsync), 32'(0));
        check("reset video_out", 32'(video_out), 32'(0));
        check("reset dropped", 32'(dropped), 32'(0));
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].mode;
            drive_frame(-1, -1, -1, -1);
            drive_frame(i, -1, -1, -1);
        end

        mode = 2'd0;
        drive_frame(-1, 1, -1, -1);
        drive_frame(0, -1, -1, -1);

        mode = 2'd0;
        drive_frame(-1, -1, 1, -1);
        drive_frame(0, -1, -1, -1);
        drive_frame(1, -1, -1, -1);

        mode = 2'd0;
        drive_frame(-1, -1, -1, -1);
        drive_frame(-1, -1, -1, 8);
        drive_frame(-1, -1, -1, -1);
        drive_frame(0, -1, -1, -1);

        check("scoreboard drained", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
